lite_regbank: RTL and testbench

//  Parametrised Xillybus Lite register bank; successor to the fixed 32x32 lite array in the ilemt top level.

---
 rtl/lite_regbank.sv | 115 +++++++++++
 tb/tb_lite_regbank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lite_regbank.sv
// Xillybus Lite register bank: N_CTRL byte-strobed control words, read-only
// version and status words, a sticky W1C event register with interrupt mask,
// and a write-only word that produces one-cycle pulse strobes.
module lite_regbank #(
  parameter int          N_CTRL   = 16,
  parameter int          N_STATUS = 32,
  parameter int          N_EVENT  = 8,
  parameter logic [31:0] VERSION  = 32'h0001_0000
) (
  input  logic                  user_clk,
  input  logic                  user_rst_n,
  input  logic                  user_wren,
  input  logic [3:0]            user_wstrb,
  input  logic                  user_rden,
  input  logic [31:0]           user_addr,
  input  logic [31:0]           user_wr_data,
  output logic [31:0]           user_rd_data,
  output logic                  user_irq,
  output logic [32*N_CTRL-1:0]  ctrl_out,
  input  logic [N_STATUS-1:0]   status_in,
  input  logic [N_EVENT-1:0]    event_in,
  output logic [31:0]           pulse_out
);

  localparam logic [5:0] W_VERSION = 6'h30;
  localparam logic [5:0] W_STATUS  = 6'h31;
  localparam logic [5:0] W_EVENT   = 6'h32;
  localparam logic [5:0] W_MASK    = 6'h33;
  localparam logic [5:0] W_PULSE   = 6'h34;

  // Expand the four byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  logic [5:0]         w;
  logic [31:0]        wmask;
  logic [31:0]        wdata_m;
  logic               wr_evt;
  logic               wr_mask;
  logic               wr_pulse;
  logic [N_EVENT-1:0] evt;
  logic [N_EVENT-1:0] irq_mask;
  logic [N_EVENT-1:0] clr;
  logic [31:0]        rd_word;
  logic               unused_addr;

  // Only the word index is decoded, so the map aliases every 256 bytes.
  assign w           = user_addr[7:2];
  assign unused_addr = ^{user_addr[31:8], user_addr[1:0]};
  assign wmask       = lane_mask(user_wstrb);
  assign wdata_m     = user_wr_data & wmask;
  assign wr_evt      = user_wren && (w == W_EVENT);
  assign wr_mask     = user_wren && (w == W_MASK);
  assign wr_pulse    = user_wren && (w == W_PULSE);
  assign clr         = wr_evt ? wdata_m[N_EVENT-1:0] : '0;

  // Control words: byte-lane writes straight into the output flops.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ctrl_out <= '0;
    end else if (user_wren) begin
      for (int k = 0; k < N_CTRL; k++) begin
        if (w == 6'(k))
          ctrl_out[32*k +: 32] <= (ctrl_out[32*k +: 32] & ~wmask) | wdata_m;
      end
    end
  end

  // Sticky events: a new event in the same cycle as a clear keeps the bit set.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) evt <= '0;
    else             evt <= event_in | (evt & ~clr);
  end

  // Interrupt mask: plain byte-lane RW on the implemented bits only.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n)  irq_mask <= '0;
    else if (wr_mask) irq_mask <= (irq_mask & ~wmask[N_EVENT-1:0]) | wdata_m[N_EVENT-1:0];
  end

  // Pulse strobes last exactly the cycle after the write, then return to 0.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) pulse_out <= '0;
    else             pulse_out <= wr_pulse ? wdata_m : 32'h0;
  end

  // Level interrupt registered from the current event and mask state.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) user_irq <= 1'b0;
    else             user_irq <= |(evt & irq_mask);
  end

  // Read mux from current state, so a same-cycle write returns the old value.
  always_comb begin
    rd_word = 32'h0;
    for (int k = 0; k < N_CTRL; k++) begin
      if (w == 6'(k)) rd_word = ctrl_out[32*k +: 32];
    end
    case (w)
      W_VERSION: rd_word = VERSION;
      W_STATUS:  rd_word[N_STATUS-1:0] = status_in;
      W_EVENT:   rd_word[N_EVENT-1:0] = evt;
      W_MASK:    rd_word[N_EVENT-1:0] = irq_mask;
      default:   ;
    endcase
  end

  // Read data register: loads on a read strobe, holds otherwise.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n)    user_rd_data <= 32'h0;
    else if (user_rden) user_rd_data <= rd_word;
  end

endmodule

// File: tb/tb_lite_regbank.sv
// Testbench for lite_regbank: directed steps followed by random traffic,
// all outputs compared each cycle against a register-map reference model.
module tb_lite_regbank;
  localparam int          N_CTRL   = 16;
  localparam int          N_STATUS = 32;
  localparam int          N_EVENT  = 8;
  localparam logic [31:0] VERSION  = 32'h0001_0000;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 wren = 1'b0;
  logic                 rden = 1'b0;
  logic [3:0]           wstrb = 4'h0;
  logic [31:0]          addr = 32'h0;
  logic [31:0]          wdata = 32'h0;
  logic [31:0]          rd_data;
  logic                 irq;
  logic [32*N_CTRL-1:0] ctrl_out;
  logic [N_STATUS-1:0]  status_in = '0;
  logic [N_EVENT-1:0]   event_in = '0;
  logic [31:0]          pulse_out;

  always #5 clk = ~clk;

  lite_regbank #(.N_CTRL(N_CTRL), .N_STATUS(N_STATUS), .N_EVENT(N_EVENT), .VERSION(VERSION)) dut (
    .user_clk(clk), .user_rst_n(rst_n), .user_wren(wren), .user_wstrb(wstrb),
    .user_rden(rden), .user_addr(addr), .user_wr_data(wdata), .user_rd_data(rd_data),
    .user_irq(irq), .ctrl_out(ctrl_out), .status_in(status_in), .event_in(event_in),
    .pulse_out(pulse_out)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state, in register-map terms.
  logic [31:0] m_ctrl [N_CTRL];
  logic [31:0] m_event, m_mask, m_rd, m_pulse;
  logic        m_irq;

  function automatic logic [31:0] strobe_data(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int w);
    if (w < N_CTRL) return m_ctrl[w];
    if (w == 'h30) return VERSION;
    if (w == 'h31) return 32'(status_in);
    if (w == 'h32) return m_event;
    if (w == 'h33) return m_mask;
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_CTRL; k++) m_ctrl[k] = 32'h0;
    m_event = 0; m_mask = 0; m_rd = 0; m_pulse = 0; m_irq = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model from the driven inputs, then compare outputs.
  task automatic tick();
    int          w;
    logic [31:0] md, bm, n_rd, n_event, n_mask, n_pulse;
    logic        n_irq;
    w       = int'(addr[7:2]);
    md      = strobe_data(wdata, wstrb);
    bm      = strobe_data(32'hFFFF_FFFF, wstrb);
    n_rd    = rden ? m_read(w) : m_rd;
    n_event = (32'(event_in) | (m_event & ~((wren && w == 'h32) ? md : 32'h0))) & 32'hFF;
    n_mask  = (wren && w == 'h33) ? (((m_mask & ~bm) | md) & 32'hFF) : m_mask;
    n_irq   = (m_event & m_mask) != 0;
    n_pulse = (wren && w == 'h34) ? md : 32'h0;
    @(posedge clk);
    #1;
    if (wren && w < N_CTRL) m_ctrl[w] = (m_ctrl[w] & ~bm) | md;
    m_rd = n_rd; m_event = n_event; m_mask = n_mask; m_irq = n_irq; m_pulse = n_pulse;
    check("rd_data", rd_data, m_rd);
    check("irq", 32'(irq), 32'(m_irq));
    check("pulse", pulse_out, m_pulse);
    for (int k = 0; k < N_CTRL; k++) check($sformatf("ctrl%0d", k), ctrl_out[32*k +: 32], m_ctrl[k]);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wdata = d; wstrb = s; wren = 1'b1;
    tick();
    wren = 1'b0; wstrb = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a; rden = 1'b1;
    tick();
    rden = 1'b0;
  endtask

  logic [32*N_CTRL-1:0] saved;
  int wsel;
  int choices [8] = '{0, 3, 15, 16, 'h31, 'h32, 'h33, 'h34};

  initial begin
    model_reset();
    #1;
    check("rst_rd", rd_data, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ctrl", 32'(ctrl_out != '0), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: reset values
    for (int k = 0; k < N_CTRL; k++) begin
      rd(32'(k) << 2);
      check("t1_ctrl", rd_data, 32'h0);
    end
    rd(32'h32 << 2); check("t1_event", rd_data, 32'h0);
    rd(32'h33 << 2); check("t1_mask", rd_data, 32'h0);
    rd(32'h30 << 2); check("t1_version", rd_data, 32'h0001_0000);

    // 2: byte strobes
    wr(32'hC, 32'hAABB_CCDD, 4'hF);
    wr(32'hC, 32'h1122_3344, 4'b0101);
    rd(32'hC);
    check("t2_rd", rd_data, 32'hAA22_CC44);
    check("t2_ctrl", ctrl_out[3*32 +: 32], 32'hAA22_CC44);
    wr(32'h8, 32'h1234_5678, 4'h0);
    check("t2_nostrb", ctrl_out[2*32 +: 32], 32'h0);

    // 3: alias and range
    wr(32'h100, 32'h5, 4'hF);
    check("t3_alias", ctrl_out[31:0], 32'h5);
    rd(32'h3F << 2); check("t3_hole", rd_data, 32'h0);
    saved = ctrl_out;
    wr(32'(N_CTRL) << 2, 32'hFFFF_FFFF, 4'hF);
    check("t3_range", 32'(ctrl_out != saved), 32'h0);

    // 4: event and interrupt
    wr(32'h33 << 2, 32'h4, 4'hF);
    event_in = 8'h04; tick(); event_in = 8'h00;
    check("t4_irq_lat", 32'(irq), 32'h0);
    rd(32'h32 << 2);
    check("t4_event", rd_data, 32'h4);
    check("t4_irq", 32'(irq), 32'h1);
    event_in = 8'h04; wr(32'h32 << 2, 32'h4, 4'hF); event_in = 8'h00;
    rd(32'h32 << 2); check("t4_setwins", rd_data, 32'h4);
    wr(32'h32 << 2, 32'h4, 4'hF);
    check("t4_irq_hold", 32'(irq), 32'h1);
    tick();
    check("t4_irq_drop", 32'(irq), 32'h0);
    rd(32'h32 << 2); check("t4_cleared", rd_data, 32'h0);

    // 5: pulse strobes
    wr(32'h34 << 2, 32'h81, 4'h1);
    check("t5_pulse", pulse_out, 32'h81);
    tick();
    check("t5_pulse_end", pulse_out, 32'h0);
    wr(32'h34 << 2, 32'hF0F0_F0F0, 4'hC);
    check("t5_b2b_a", pulse_out, 32'hF0F0_0000);
    wr(32'h34 << 2, 32'h0000_0102, 4'h3);
    check("t5_b2b_b", pulse_out, 32'h0000_0102);
    rd(32'h34 << 2); check("t5_rd", rd_data, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      wsel      = choices[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) wsel = $urandom_range(0, 63);
      addr      = {$urandom_range(0, 255) == 0 ? 24'h0 : 24'($urandom), 6'(wsel), 2'($urandom)};
      wren      = $urandom_range(0, 1) == 1;
      rden      = $urandom_range(0, 1) == 1;
      wstrb     = 4'($urandom);
      wdata     = $urandom;
      status_in = $urandom;
      event_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      tick();
    end
    wren = 1'b0; rden = 1'b0; event_in = 8'h0;

    // 6: async reset mid-read with interrupt active
    wr(32'h33 << 2, 32'h4, 4'hF);
    wr(32'hC, 32'hDEAD_BEEF, 4'hF);
    event_in = 8'h04; tick(); event_in = 8'h00;
    tick();
    check("t6_irq_pre", 32'(irq), 32'h1);
    rd(32'hC);
    check("t6_rd_pre", rd_data, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    check("t6_rd", rd_data, 32'h0);
    check("t6_irq", 32'(irq), 32'h0);
    check("t6_ctrl", 32'(ctrl_out != '0), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd(32'hC); check("t6_after", rd_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard cycle bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end
endmodule
